// File: rtl/game_sequencer.sv
`timescale 1ns/1ps
// game_sequencer: IDLE/RUN/PAUSE/OVER flow, vsync-to-frame_tick divider, button debounce and core reset.
// Define DEMO_MODE_EN to make IDLE an attract mode that runs the core at the slowest speed.
module game_sequencer #(
  parameter int HIT_LIMIT       = 50,
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int OVER_FRAMES     = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_start,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [1:0] speed,
  input  logic [7:0] hits0,
  input  logic [7:0] hits1,
  input  logic [7:0] hits2,
  input  logic [7:0] hits3,
  output logic       frame_tick,
  output logic       core_rst_n,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic       winner_valid
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]  OVER_LAST = 10'(OVER_FRAMES - 1);
  localparam logic [7:0]  HIT_LIM   = 8'(HIT_LIMIT);

  logic [1:0] btn_raw;
  logic [1:0] press_next;
  logic [1:0] press_vec;

  assign btn_raw = {btn_pause, btn_start};

  // bit 0 = start, bit 1 = pause; press_next lets attract mode see a press one cycle early
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]  sync_reg;
      logic [15:0] cnt_reg;
      logic        level_reg;
      logic        level_next;
      logic        press_reg;
      logic        differs;

      assign differs        = sync_reg[1] != level_reg;
      assign level_next     = (differs && cnt_reg == DB_LAST) ? sync_reg[1] : level_reg;
      assign press_next[gi] = level_next & ~level_reg;
      assign press_vec[gi]  = press_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg  <= 2'b00;
          cnt_reg   <= 16'd0;
          level_reg <= 1'b0;
          press_reg <= 1'b0;
        end else begin
          sync_reg  <= {sync_reg[0], btn_raw[gi]};
          level_reg <= level_next;
          press_reg <= press_next[gi];
          cnt_reg   <= (differs && cnt_reg != DB_LAST) ? cnt_reg + 16'd1 : 16'd0;
        end
      end
    end
  endgenerate

  logic [7:0] hits [4];
  logic       any_hit;
  logic [1:0] hit_idx;

  assign hits[0] = hits0;
  assign hits[1] = hits1;
  assign hits[2] = hits2;
  assign hits[3] = hits3;

  // descending scan so the lowest qualifying index is the one left standing
  always_comb begin
    any_hit = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hits[i] >= HIT_LIM) begin
        any_hit = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  state_t     state_reg, state_next;
  logic [1:0] div_reg, div_next;
  logic [9:0] over_reg, over_next;
  logic       tick_reg, tick_next;
  logic       core_reg, core_next;
  logic [1:0] winner_reg, winner_next;
  logic       wv_reg, wv_next;
  logic       ticking;
  logic [1:0] spd;
  logic       tick_due;
  logic       keep_div;

  always_comb begin
`ifdef DEMO_MODE_EN
    ticking = (state_reg == S_RUN) || (state_reg == S_IDLE);
    spd     = (state_reg == S_IDLE) ? 2'd3 : speed;
`else
    ticking = (state_reg == S_RUN);
    spd     = speed;
`endif
    // vsync pulses seen while the core is held in reset do not count
    tick_due = ticking && core_reg && vsync_start && (div_reg >= spd);
  end

  always_comb begin
    state_next  = state_reg;
    div_next    = div_reg;
    over_next   = over_reg;
    winner_next = winner_reg;
    wv_next     = wv_reg;
    case (state_reg)
      S_IDLE: begin
        if (press_vec[0]) state_next = S_RUN;
      end
      S_RUN: begin
        if (any_hit) begin
          state_next  = S_OVER;
          winner_next = hit_idx;
          wv_next     = 1'b1;
        end else if (press_vec[1]) begin
          state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (press_vec[0])      state_next = S_IDLE;
        else if (press_vec[1]) state_next = S_RUN;
      end
      default: begin
        if (vsync_start) over_next = over_reg + 10'd1;
        if (press_vec[0] || (vsync_start && over_reg == OVER_LAST)) begin
          state_next = S_IDLE;
          over_next  = 10'd0;
          wv_next    = 1'b0;
        end
      end
    endcase

    if (ticking && core_reg && vsync_start) div_next = tick_due ? 2'd0 : div_reg + 2'd1;

    keep_div = ((state_reg == S_RUN) && (state_next == S_PAUSE)) ||
               ((state_reg == S_PAUSE) && (state_next == S_RUN));
    if (state_next != state_reg) div_next = keep_div ? div_reg : 2'd0;

    tick_next = tick_due && (state_next == state_reg);

`ifdef DEMO_MODE_EN
    // drop reset one cycle ahead of the IDLE->RUN transition cycle
    if (state_reg == S_IDLE) core_next = (state_next == S_IDLE) && !press_next[0];
    else                     core_next = (state_next != S_IDLE);
`else
    core_next = (state_reg != S_IDLE) && (state_next != S_IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      div_reg    <= 2'd0;
      over_reg   <= 10'd0;
      tick_reg   <= 1'b0;
      core_reg   <= 1'b0;
      winner_reg <= 2'd0;
      wv_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      div_reg    <= div_next;
      over_reg   <= over_next;
      tick_reg   <= tick_next;
      core_reg   <= core_next;
      winner_reg <= winner_next;
      wv_reg     <= wv_next;
    end
  end

  assign state        = state_reg;
  assign frame_tick   = tick_reg;
  assign core_rst_n   = core_reg;
  assign winner       = winner_reg;
  assign winner_valid = wv_reg;
endmodule

// File: tb/tb_game_sequencer.sv
`timescale 1ns/1ps
// tb_game_sequencer: directed stimulus pushes expected output events (with cycle stamps)
// into a scoreboard; a negedge monitor pops and compares each observed output change.
module tb_game_sequencer;
  localparam int K_STATE = 0;
  localparam int K_CORE  = 1;
  localparam int K_WV    = 2;
  localparam int K_WIN   = 3;
  localparam int K_TICK  = 4;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync_start = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [7:0] hits0 = 8'd0, hits1 = 8'd0, hits2 = 8'd0, hits3 = 8'd0;
  logic       frame_tick, core_rst_n, winner_valid;
  logic [1:0] state, winner;

  logic [1:0] p_state = 2'd0, p_winner = 2'd0;
  logic       p_core = 1'b0, p_wv = 1'b0;

  game_sequencer #(
    .HIT_LIMIT      (50),
    .DEBOUNCE_CYCLES(16),
    .OVER_FRAMES    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_start (vsync_start),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .speed       (speed),
    .hits0       (hits0),
    .hits1       (hits1),
    .hits2       (hits2),
    .hits3       (hits3),
    .frame_tick  (frame_tick),
    .core_rst_n  (core_rst_n),
    .state       (state),
    .winner      (winner),
    .winner_valid(winner_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_STATE: return "state";
      K_CORE:  return "core_rst_n";
      K_WV:    return "winner_valid";
      K_WIN:   return "winner";
      default: return "frame_tick";
    endcase
  endfunction

  task automatic observe(input int kind, input int val);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s=%0d at cycle %0d, required no event", kname(kind), val, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val != val || (e.cyc >= 0 && e.cyc != cyc)) begin
        errors++;
        $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end else begin
        $display("event %s=%0d at cycle %0d ok", kname(kind), val, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (state != p_state)       observe(K_STATE, int'(state));
    if (core_rst_n != p_core)   observe(K_CORE, int'(core_rst_n));
    if (winner_valid != p_wv)   observe(K_WV, int'(winner_valid));
    if (winner != p_winner)     observe(K_WIN, int'(winner));
    if (frame_tick)             observe(K_TICK, 1);
    p_state  = state;
    p_core   = core_rst_n;
    p_wv     = winner_valid;
    p_winner = winner;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic push(input int k, input int v, input int c);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_btn(input int which, input logic v, output int n);
    @(negedge clk);
    if (which == 0) btn_start = v;
    else            btn_pause = v;
    n = cyc;
  endtask

  task automatic vs_on(output int vc);
    @(negedge clk);
    vsync_start = 1'b1;
    vc = cyc;
  endtask

  task automatic vs_off();
    @(negedge clk);
    vsync_start = 1'b0;
    idle(3);
  endtask

  task automatic pulse(input bit exp_tick);
    int vc;
    vs_on(vc);
    if (exp_tick) push(K_TICK, 1, vc + 1);
    vs_off();
  endtask

  // button held from cycle n: debounced press at n+17, state change at n+19
  task automatic start_game();
    int n;
    drive_btn(0, 1'b1, n);
`ifdef DEMO_MODE_EN
    push(K_CORE, 0, n + 18);
`endif
    push(K_STATE, 1, n + 19);
    push(K_CORE, 1, n + 20);
    idle(40);
    drive_btn(0, 1'b0, n);
    idle(40);
  endtask

  task automatic pause_btn(input int new_state);
    int n;
    drive_btn(1, 1'b1, n);
    push(K_STATE, new_state, n + 19);
    idle(40);
    drive_btn(1, 1'b0, n);
    idle(40);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_core_rst_n"}, int'(core_rst_n), 0);
    chk({tag, "_frame_tick"}, int'(frame_tick), 0);
    chk({tag, "_winner"}, int'(winner), 0);
    chk({tag, "_winner_valid"}, int'(winner_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, vc;
    logic [8:0] pat9;
    logic [2:0] pat3;
    pat9 = 9'b100_100_100;
    pat3 = 3'b101;

    idle(3);
    chk_reset_outputs("reset");
`ifdef DEMO_MODE_EN
    push(K_CORE, 1, -1);
`endif
    rst_n = 1'b1;
    idle(5);

    // bouncing start button (5-cycle levels) must not register, then a clean hold
    for (int i = 0; i < 20; i++) begin
      drive_btn(0, (i % 2) == 0, n);
      idle(4);
    end
    start_game();

    speed = 2'd2;
    for (int i = 0; i < 9; i++) pulse(pat9[i]);
    speed = 2'd0;
    for (int i = 0; i < 3; i++) pulse(1'b1);
    speed = 2'd3;
    pulse(1'b0);
    pulse(1'b0);
    speed = 2'd1;
    for (int i = 0; i < 3; i++) pulse(pat3[i]);

    speed = 2'd2;
    pulse(1'b0);
    pause_btn(2);
    for (int i = 0; i < 5; i++) pulse(1'b0);
    pause_btn(1);
    pulse(1'b0);
    pulse(1'b1);

    // win lands in the same cycle as the pause press and a would-be tick
    speed = 2'd0;
    drive_btn(1, 1'b1, n);
    push(K_STATE, 3, n + 19);
    push(K_WV, 1, n + 19);
    push(K_WIN, 1, n + 19);
    idle(18);
    hits1 = 8'd50;
    hits2 = 8'd50;
    vsync_start = 1'b1;
    idle(1);
    vsync_start = 1'b0;
    idle(40);
    drive_btn(1, 1'b0, n);
    idle(40);

    for (int i = 0; i < 3; i++) pulse(1'b0);
    vs_on(vc);
    push(K_STATE, 0, vc + 1);
    push(K_CORE, 0, vc + 1);
    push(K_WV, 0, vc + 1);
`ifdef DEMO_MODE_EN
    push(K_CORE, 1, vc + 2);
`endif
    vs_off();
    idle(5);
`ifdef DEMO_MODE_EN
    for (int i = 0; i < 4; i++) pulse(i == 3);
`else
    for (int i = 0; i < 4; i++) pulse(1'b0);
`endif

    hits1 = 8'd0;
    hits2 = 8'd0;
    start_game();

    push(K_STATE, 0, -1);
    push(K_CORE, 0, -1);
    push(K_WIN, 0, -1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    idle(3);
`ifdef DEMO_MODE_EN
    push(K_CORE, 1, -1);
`endif
    rst_n = 1'b1;
    idle(5);
    chk("state_after_release", int'(state), 0);

    for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: got nothing, required %s=%0d at cycle %0d", kname(e.kind), e.val, e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
